// File: rtl/crossy_pkg.sv
// crossy_pkg: shared round states, grid type and car-field lookup for the crossing game.
package crossy_pkg;

    localparam int GRID_N = 16;

    typedef enum logic [2:0] {IDLE, PLAY, HIT, LVLUP, OVER} round_state_t;

    typedef logic [GRID_N-1:0][GRID_N-1:0] grid_t;

    // Column 0 is the leftmost cell, which is the MSB of the row word.
    function automatic logic cell_at(grid_t g, logic [3:0] row, logic [3:0] col);
        return g[row][~col];
    endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running game tick, a registered 1-cycle pulse every DIV clocks.
module tick_divider #(
    parameter int DIV = 833_333
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CW'(DIV - 1));
        cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/lane_round_ctrl.sv
// lane_round_ctrl: round FSM for the car-lane field (lane pacing, collisions, lives, level).
// Optional CROSSY_BONUS_LIFE_EN grants an extra life on every fourth level.
module lane_round_ctrl
    import crossy_pkg::*;
#(
    parameter int TICK_DIV     = 833_333,
    parameter int STEP_BASE    = 8,
    parameter int FREEZE_TICKS = 120,
    parameter int START_LIVES  = 3,
    parameter int MAX_LEVEL    = 15,
    parameter int GOAL_ROW     = 15
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [3:0]                     frog_row,
    input  logic [3:0]                     frog_col,
    input  logic [GRID_N-1:0][GRID_N-1:0]  grid_in,
    output logic                           hit,
    output logic                           lane_step,
    output logic                           field_reseed,
    output logic                           frog_home,
    output logic [2:0]                     lives,
    output logic [3:0]                     level,
    output logic                           game_over
);

    localparam int         SW         = $clog2(STEP_BASE + 1);
    localparam int         FW         = $clog2(FREEZE_TICKS + 2);
    localparam logic [2:0] LIVES_INIT = 3'(START_LIVES);
    localparam logic [3:0] LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [3:0] GOAL       = 4'(GOAL_ROW);

    round_state_t  state_q, state_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d, step_top;
    logic [FW-1:0] frz_cnt_q, frz_cnt_d;
    logic [2:0]    lives_q, lives_d;
    logic [3:0]    level_q, level_d, level_inc;
    logic          hit_q, hit_d;
    logic          lane_step_q, lane_step_d;
    logic          field_reseed_q, field_reseed_d;
    logic          frog_home_q, frog_home_d;
    logic          game_over_q, game_over_d;
    logic          tick, collide, freeze_done;

    tick_divider #(.DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_comb begin
        collide     = cell_at(grid_in, frog_row, frog_col);
        step_top    = (int'(level_q) >= STEP_BASE - 1) ? '0 : SW'(STEP_BASE - 1 - int'(level_q));
        level_inc   = (level_q >= LEVEL_MAX) ? level_q : level_q + 4'd1;
        freeze_done = (frz_cnt_q == '0) || (tick && frz_cnt_q == FW'(1));
        state_d        = state_q;
        step_cnt_d     = '0;
        frz_cnt_d      = frz_cnt_q;
        lives_d        = lives_q;
        level_d        = level_q;
        lane_step_d    = 1'b0;
        field_reseed_d = 1'b0;
        frog_home_d    = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d        = PLAY;
                    lives_d        = LIVES_INIT;
                    level_d        = '0;
                    field_reseed_d = 1'b1;
                    frog_home_d    = 1'b1;
                end
            end
            PLAY: begin
                // Collision outranks reaching the goal row in the same cycle.
                if (collide) begin
                    state_d   = HIT;
                    lives_d   = (lives_q == '0) ? '0 : lives_q - 3'd1;
                    frz_cnt_d = FW'(FREEZE_TICKS);
                end else if (frog_row == GOAL) begin
                    state_d = LVLUP;
                end else if (tick) begin
                    lane_step_d = (step_cnt_q == step_top);
                    step_cnt_d  = lane_step_d ? '0 : step_cnt_q + SW'(1);
                end else begin
                    step_cnt_d = step_cnt_q;
                end
            end
            HIT: begin
                if (tick && frz_cnt_q != '0) frz_cnt_d = frz_cnt_q - FW'(1);
                if (freeze_done) begin
                    state_d     = (lives_q == '0) ? OVER : PLAY;
                    frog_home_d = (lives_q != '0);
                end
            end
            LVLUP: begin
                state_d        = PLAY;
                level_d        = level_inc;
                field_reseed_d = 1'b1;
                frog_home_d    = 1'b1;
`ifdef CROSSY_BONUS_LIFE_EN
                if (level_inc[1:0] == 2'b00 && lives_q != 3'd7) lives_d = lives_q + 3'd1;
`endif
            end
            default: state_d = IDLE;
        endcase
        hit_d       = (state_d == HIT) || (state_d == OVER);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            step_cnt_q     <= '0;
            frz_cnt_q      <= '0;
            lives_q        <= LIVES_INIT;
            level_q        <= '0;
            hit_q          <= 1'b0;
            lane_step_q    <= 1'b0;
            field_reseed_q <= 1'b0;
            frog_home_q    <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_cnt_q     <= step_cnt_d;
            frz_cnt_q      <= frz_cnt_d;
            lives_q        <= lives_d;
            level_q        <= level_d;
            hit_q          <= hit_d;
            lane_step_q    <= lane_step_d;
            field_reseed_q <= field_reseed_d;
            frog_home_q    <= frog_home_d;
            game_over_q    <= game_over_d;
        end
    end

    assign hit          = hit_q;
    assign lane_step    = lane_step_q;
    assign field_reseed = field_reseed_q;
    assign frog_home    = frog_home_q;
    assign lives        = lives_q;
    assign level        = level_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_lane_round_ctrl.sv
// tb_lane_round_ctrl: directed round scenarios plus randomized play against a game-rules model.
module tb_lane_round_ctrl;

    localparam int TD = 4;
    localparam int SB = 4;
    localparam int FT = 3;
    localparam int SL = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       frog_row = '0;
    logic [3:0]       frog_col = '0;
    logic [15:0][15:0] grid_in = '0;
    logic             hit, lane_step, field_reseed, frog_home, game_over;
    logic [2:0]       lives;
    logic [3:0]       level;

    always #5 clk = ~clk;

    lane_round_ctrl #(
        .TICK_DIV(TD), .STEP_BASE(SB), .FREEZE_TICKS(FT),
        .START_LIVES(SL), .MAX_LEVEL(15), .GOAL_ROW(15)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .frog_row(frog_row), .frog_col(frog_col), .grid_in(grid_in),
        .hit(hit), .lane_step(lane_step), .field_reseed(field_reseed),
        .frog_home(frog_home), .lives(lives), .level(level), .game_over(game_over)
    );

    int n_checks = 0;
    int n_errs = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game-rules model: mode, remaining lives, level, ticks since entering play.
    localparam int M_IDLE = 0, M_PLAY = 1, M_HIT = 2, M_LVL = 3, M_OVER = 4;
    int m_mode = M_IDLE, m_lives = SL, m_level = 0, m_ticks = 0, m_frz = 0, cyc = 0;
    int e_step = 0, e_reseed = 0, e_home = 0;
    bit tk, col_now;

    function automatic int period(int lv);
        return (SB - lv > 1) ? SB - lv : 1;
    endfunction

    always begin
        @(posedge clk);
        if (!reset) begin
            m_mode = M_IDLE; m_lives = SL; m_level = 0; m_ticks = 0; m_frz = 0; cyc = 0;
            e_step = 0; e_reseed = 0; e_home = 0;
        end else begin
            tk = (cyc > 0) && (cyc % TD == 0);
            col_now = grid_in[frog_row][15 - int'(frog_col)];
            e_step = 0; e_reseed = 0; e_home = 0;
            case (m_mode)
                M_IDLE, M_OVER: if (start) begin
                    m_mode = M_PLAY; m_lives = SL; m_level = 0; m_ticks = 0;
                    e_reseed = 1; e_home = 1;
                end
                M_PLAY: begin
                    if (col_now) begin
                        m_mode = M_HIT; m_lives = (m_lives > 0) ? m_lives - 1 : 0; m_frz = FT;
                    end else if (frog_row == 4'd15) begin
                        m_mode = M_LVL;
                    end else if (tk) begin
                        m_ticks++;
                        if (m_ticks % period(m_level) == 0) e_step = 1;
                    end
                end
                M_HIT: begin
                    if (tk && m_frz > 0) m_frz--;
                    if (m_frz == 0) begin
                        if (m_lives == 0) m_mode = M_OVER;
                        else begin m_mode = M_PLAY; m_ticks = 0; e_home = 1; end
                    end
                end
                default: begin
                    m_level = (m_level < 15) ? m_level + 1 : 15;
`ifdef CROSSY_BONUS_LIFE_EN
                    if (m_level % 4 == 0 && m_lives < 7) m_lives++;
`endif
                    e_reseed = 1; e_home = 1; m_mode = M_PLAY; m_ticks = 0;
                end
            endcase
            cyc++;
        end
        #1;
        check("m_hit", hit, int'(m_mode == M_HIT || m_mode == M_OVER));
        check("m_game_over", game_over, int'(m_mode == M_OVER));
        check("m_lane_step", lane_step, e_step);
        check("m_field_reseed", field_reseed, e_reseed);
        check("m_frog_home", frog_home, e_home);
        check("m_lives", lives, m_lives);
        check("m_level", level, m_level);
    end

    task automatic step_gap(input string name, input int exp);
        int n = 0;
        int g = -1;
        @(negedge clk);
        while (!lane_step && n < 100) begin @(negedge clk); n++; end
        if (lane_step) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!lane_step && n < 100);
            if (lane_step) g = n;
        end
        check(name, g, exp);
    endtask

    task automatic goal_visit();
        @(negedge clk); frog_row = 4'd15;
        @(negedge clk); frog_row = 4'd0;
        repeat (2) @(negedge clk);
    endtask

    // Place the car under the frog during a tick cycle so the freeze spans three full tick periods.
    task automatic collide_at_tick(input int row, input int col);
        int n = 0;
        @(negedge clk);
        while (!(cyc > 0 && cyc % TD == 0) && n < 10) begin @(negedge clk); n++; end
        grid_in[row][15 - col] = 1'b1;
        frog_row = 4'(row);
        frog_col = 4'(col);
        @(negedge clk);
    endtask

    int n, lives_before;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_hit", hit, 0);
        check("rst_lane_step", lane_step, 0);
        check("rst_reseed", field_reseed, 0);
        check("rst_home", frog_home, 0);
        check("rst_over", game_over, 0);
        check("rst_lives", lives, 2);
        check("rst_level", level, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("start_reseed", field_reseed, 1);
        check("start_home", frog_home, 1);
        start = 1'b0;
        @(negedge clk);
        check("reseed_width", field_reseed, 0);
        check("home_width", frog_home, 0);
        step_gap("gap_level0", 16);
        repeat (3) goal_visit();
        check("level_after_3", level, 3);
        step_gap("gap_level3", 4);

        collide_at_tick(5, 0);
        check("hit1_hit", hit, 1);
        check("hit1_lives", lives, 1);
        frog_row = 4'd0;
        n = 1;
        @(negedge clk);
        while (hit && n < 40) begin @(negedge clk); n++; end
        check("hit1_hold", n, 12);
        check("hit1_home", frog_home, 1);
        check("hit1_level", level, 3);

        collide_at_tick(5, 0);
        check("hit2_lives", lives, 0);
        frog_row = 4'd0;
        n = 1;
        @(negedge clk);
        while (!game_over && n < 40) begin @(negedge clk); n++; end
        check("over_delay", n, 12);
        check("over_hit", hit, 1);
        grid_in = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_lives", lives, 2);
        check("restart_level", level, 0);
        check("restart_over", game_over, 0);
        check("restart_hit", hit, 0);

        repeat (16) goal_visit();
        check("level_sat", level, 15);
`ifdef CROSSY_BONUS_LIFE_EN
        check("bonus_lives", lives, 5);
`else
        check("no_bonus_lives", lives, 2);
`endif
        step_gap("gap_level15", 4);

        lives_before = int'(lives);
        @(negedge clk);
        grid_in[15][15 - 3] = 1'b1;
        frog_row = 4'd15;
        frog_col = 4'd3;
        @(negedge clk);
        check("goal_collide_hit", hit, 1);
        check("goal_collide_level", level, 15);
        check("goal_collide_lives", lives, lives_before - 1);
        frog_row = 4'd0;
        n = 0;
        while (hit && n < 40) begin @(negedge clk); n++; end
        grid_in = '0;
        repeat (5) @(negedge clk);

        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_hit", hit, 0);
        check("async_lane_step", lane_step, 0);
        check("async_reseed", field_reseed, 0);
        check("async_home", frog_home, 0);
        check("async_over", game_over, 0);
        check("async_lives", lives, 2);
        check("async_level", level, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!reset) reset = 1'b1;
            else if ($urandom % 500 == 0) reset = 1'b0;
            start = ($urandom % 8 == 0);
            frog_row = ($urandom % 24 == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            frog_col = 4'($urandom_range(0, 15));
            for (int r = 0; r < 16; r++)
                grid_in[r] = ($urandom % 4 == 0) ? 16'($urandom & $urandom & $urandom) : 16'h0;
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
